// File: rtl/btn_repeat_counter_ctrl.sv
// ---------------------------------------------------------------------------
// btn_repeat_counter_ctrl
//
// Push-button controller for a two-digit 7-segment counter. The active-low
// buttons are synchronised, then sampled on a slow tick by a
// press / hold / auto-repeat FSM. The FSM drives a wrapping 0..MAX_VAL count,
// and registered active-low segment codes for the ones and tens digits.
//
// Parameters
//   TICK_DIV    CLK cycles per sample tick (>= 2)
//   REPEAT_DLY  ticks a key is held, including the first, before repeat (>= 1)
//   MAX_VAL     inclusive count upper bound (1..99)
//
// Ports
//   CLK        in   system clock, posedge
//   RST_N      in   asynchronous active-low reset
//   btn[3:0]   in   active-low buttons: [0]=up [1]=down [2]=clear [3]=unused
//   count[6:0] out  current count, binary
//   BCD[7:0]   out  ones-digit segment code, active-low
//   BCD1[7:0]  out  tens-digit segment code, active-low
//   step       out  one-CLK pulse per executed action
//   repeating  out  high while the FSM is in auto-repeat
// ---------------------------------------------------------------------------
module btn_repeat_counter_ctrl #(
   parameter int TICK_DIV   = 8388608,
   parameter int REPEAT_DLY = 5,
   parameter int MAX_VAL    = 99
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic [3:0] btn,
   output logic [6:0] count,
   output logic [7:0] BCD,
   output logic [7:0] BCD1,
   output logic       step,
   output logic       repeating
);

   localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   // Hold counter never exceeds max(REPEAT_DLY, 2).
   localparam int HW = $clog2(REPEAT_DLY + 2);

   typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;
   typedef enum logic [1:0] {CMD_NONE, CMD_UP, CMD_DN, CMD_CLR} cmd_t;

   function automatic logic [7:0] seg7(input logic [6:0] d);
      case (d)
         7'd0:    seg7 = 8'h03;
         7'd1:    seg7 = 8'h9F;
         7'd2:    seg7 = 8'h25;
         7'd3:    seg7 = 8'h0D;
         7'd4:    seg7 = 8'h99;
         7'd5:    seg7 = 8'h49;
         7'd6:    seg7 = 8'hC1;
         7'd7:    seg7 = 8'h1F;
         7'd8:    seg7 = 8'h01;
         default: seg7 = 8'h19;
      endcase
   endfunction

   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic          tick;
   logic [2:0]    sync1_q, sync2_q;
   state_t        state_q, state_d;
   logic [HW-1:0] hold_cnt_q, hold_cnt_d;
   logic [HW:0]   hold_inc;
   cmd_t          cmd;
   logic          key_none, key_valid, act;
   logic [6:0]    count_q, count_d;
   logic          step_q, repeating_q, repeating_d;
   logic [7:0]    bcd_q, bcd1_q;
   logic          btn_unused;

   // The fourth button has no function on this board.
   assign btn_unused = btn[3];

   assign tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
   assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

   // Key decode: only a single low button is a command; several low buttons
   // still count as "held" so the FSM does not fall back to IDLE.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      cmd = CMD_NONE;
      case (sync2_q)
         3'b110:  cmd = CMD_UP;
         3'b101:  cmd = CMD_DN;
         3'b011:  cmd = CMD_CLR;
         default: cmd = CMD_NONE;
      endcase
   end

   assign key_none  = (sync2_q == 3'b111);
   assign key_valid = (cmd != CMD_NONE);
   assign hold_inc  = {1'b0, hold_cnt_q} + 1'b1;

   // FSM state register
   // NOTE: asynchronous active-low reset; the reset branch lists every flop.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= IDLE;
         hold_cnt_q <= '0;
      end else begin
         // NOTE: sequential state is updated only with non-blocking assignments.
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

   // FSM next-state; nothing moves between ticks.
   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      act        = 1'b0;
      if (tick) begin
         case (state_q)
            IDLE: begin
               if (key_valid) begin
                  act        = 1'b1;
                  hold_cnt_d = HW'(1);
                  state_d    = HOLD;
               end
            end
            HOLD: begin
               if (key_none) begin
                  hold_cnt_d = '0;
                  state_d    = IDLE;
               end else begin
                  hold_cnt_d = hold_inc[HW-1:0];
                  // '>=' so that REPEAT_DLY==1 still enters on the second tick.
                  if (hold_inc >= (HW+1)'(REPEAT_DLY)) state_d = REPEAT;
               end
            end
            REPEAT: begin
               if (key_none) begin
                  hold_cnt_d = '0;
                  state_d    = IDLE;
               end else if (key_valid) begin
                  act = 1'b1;
               end
            end
            default: begin
               hold_cnt_d = '0;
               state_d    = IDLE;
            end
         endcase
      end
   end

   // FSM outputs: count update and status
   always_comb begin
      count_d     = count_q;
      repeating_d = (state_d == REPEAT);
      if (act) begin
         case (cmd)
            CMD_UP:  count_d = (count_q == 7'(MAX_VAL)) ? '0 : count_q + 7'd1;
            CMD_DN:  count_d = (count_q == '0) ? 7'(MAX_VAL) : count_q - 7'd1;
            default: count_d = '0;
         endcase
      end
   end

   // Datapath registers: tick divider, synchroniser, count, digit codes
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         tick_cnt_q  <= '0;
         sync1_q     <= 3'b111;
         sync2_q     <= 3'b111;
         count_q     <= '0;
         step_q      <= 1'b0;
         repeating_q <= 1'b0;
         bcd_q       <= 8'h03;
         bcd1_q      <= 8'h03;
      end else begin
         tick_cnt_q  <= tick_cnt_d;
         sync1_q     <= btn[2:0];
         sync2_q     <= sync1_q;
         count_q     <= count_d;
         step_q      <= act;
         repeating_q <= repeating_d;
         // Digits follow the registered count, hence one CLK behind it.
         bcd_q       <= seg7(count_q % 7'd10);
         bcd1_q      <= seg7(count_q / 7'd10);
      end
   end

   assign count     = count_q;
   assign step      = step_q;
   assign repeating = repeating_q;
   assign BCD       = bcd_q;
   assign BCD1      = bcd1_q;

endmodule

// File: tb/tb_btn_repeat_counter_ctrl.sv
// ---------------------------------------------------------------------------
// tb_btn_repeat_counter_ctrl
//
// Directed bench for btn_repeat_counter_ctrl (TICK_DIV=4, REPEAT_DLY=3,
// MAX_VAL=99). A tick-level behavioural model predicts every output and is
// compared on each falling clock edge; literal expectations pin the model.
// ---------------------------------------------------------------------------
module tb_btn_repeat_counter_ctrl;

   localparam int TICK_DIV   = 4;
   localparam int REPEAT_DLY = 3;
   localparam int MAX_VAL    = 99;
   // Held-tick count at which the key is in auto-repeat.
   localparam int RPT_TH     = (REPEAT_DLY < 2) ? 2 : REPEAT_DLY;

   logic       CLK = 1'b0;
   logic       RST_N;
   logic [3:0] btn;
   logic [6:0] count;
   logic [7:0] BCD, BCD1;
   logic       step, repeating;

   int n_cmp = 0;
   int n_err = 0;
   int n_steps = 0;
   bit cmp_en = 1'b0;

   btn_repeat_counter_ctrl #(
      .TICK_DIV  (TICK_DIV),
      .REPEAT_DLY(REPEAT_DLY),
      .MAX_VAL   (MAX_VAL)
   ) dut (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .btn      (btn),
      .count    (count),
      .BCD      (BCD),
      .BCD1     (BCD1),
      .step     (step),
      .repeating(repeating)
   );

   always #5 CLK = ~CLK;

   function automatic logic [7:0] seg(input int d);
      logic [7:0] tbl [10];
      tbl = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'hC1, 8'h1F, 8'h01, 8'h19};
      return tbl[d];
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Works in whole ticks: m_held counts consecutive held ticks since a valid
   // press; an action fires on the first one and on every tick beyond RPT_TH.
   logic [2:0] m_h1, m_h2;
   int         m_cyc, m_held, m_count;
   logic       m_step, m_rep;
   logic [7:0] m_bcd, m_bcd1;

   always @(posedge CLK or negedge RST_N) begin
      int         cyc, held, cnt, lows;
      logic       fire;
      logic [2:0] key;
      if (!RST_N) begin
         m_h1    <= 3'b111;
         m_h2    <= 3'b111;
         m_cyc   <= 0;
         m_held  <= 0;
         m_count <= 0;
         m_step  <= 1'b0;
         m_rep   <= 1'b0;
         m_bcd   <= 8'h03;
         m_bcd1  <= 8'h03;
      end else begin
         key  = m_h2;  // buttons as they were two edges ago
         cyc  = m_cyc + 1;
         held = m_held;
         cnt  = m_count;
         fire = 1'b0;
         lows = 0;
         for (int i = 0; i < 3; i++) if (!key[i]) lows++;
         if (cyc % TICK_DIV == 0) begin
            if (lows == 0) held = 0;
            else if (held == 0) begin
               if (lows == 1) begin
                  held = 1;
                  fire = 1'b1;
               end
            end else begin
               if (held < 1000) held++;
               if (held > RPT_TH && lows == 1) fire = 1'b1;
            end
            if (fire) begin
               if (!key[0])      cnt = (cnt == MAX_VAL) ? 0 : cnt + 1;
               else if (!key[1]) cnt = (cnt == 0) ? MAX_VAL : cnt - 1;
               else              cnt = 0;
            end
         end
         m_bcd   <= seg(m_count % 10);
         m_bcd1  <= seg(m_count / 10);
         m_h2    <= m_h1;
         m_h1    <= btn[2:0];
         m_cyc   <= cyc % TICK_DIV;
         m_held  <= held;
         m_count <= cnt;
         m_step  <= fire;
         m_rep   <= (held >= RPT_TH);
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge CLK) begin
      if (cmp_en) begin
         check("count",     int'(count),     m_count);
         check("step",      int'(step),      int'(m_step));
         check("repeating", int'(repeating), int'(m_rep));
         check("BCD",       int'(BCD),       int'(m_bcd));
         check("BCD1",      int'(BCD1),      int'(m_bcd1));
      end
   end

   always @(negedge CLK) if (step === 1'b1) n_steps++;

   // ---------------- stimulus ----------------
   task automatic cycles(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST_N = 1'b0;
      cycles(2);
      RST_N = 1'b1;
      n_steps = 0;
   endtask

   // Drive a pattern for exactly n ticks (any TICK_DIV consecutive cycles
   // contain one tick), with no release afterwards.
   task automatic hold_for(input logic [3:0] b, input int ticks);
      btn = b;
      cycles(ticks * TICK_DIV);
   endtask

   task automatic press(input logic [3:0] b, input int ticks);
      @(negedge CLK);
      hold_for(b, ticks);
      btn = 4'hF;
      cycles(3 * TICK_DIV);
   endtask

   initial begin
      int s0;
      RST_N = 1'b0;
      btn   = 4'hF;
      cycles(2);
      cmp_en = 1'b1;
      do_reset();

      // 1: idle after reset
      cycles(5 * TICK_DIV);
      check("t1_count", int'(count), 0);
      check("t1_bcd",   int'(BCD),   8'h03);
      check("t1_bcd1",  int'(BCD1),  8'h03);
      check("t1_steps", n_steps,     0);

      // 2: single short press of up
      press(4'b1110, 1);
      check("t2_count", int'(count),     1);
      check("t2_bcd",   int'(BCD),       8'h9F);
      check("t2_steps", n_steps,         1);
      check("t2_rep",   int'(repeating), 0);

      // 3: hold up for 8 ticks
      do_reset();
      @(negedge CLK);
      btn = 4'b1110;
      cycles(11);  // just past the third tick
      check("t3_rep_rise", int'(repeating), 1);
      check("t3_mid_count", int'(count), 1);
      cycles(21);
      btn = 4'hF;
      cycles(3 * TICK_DIV);
      check("t3_count", int'(count), 6);
      check("t3_steps", n_steps,     6);

      // 4: wrap both ways
      do_reset();
      press(4'b1101, 1);
      check("t4_dn_wrap", int'(count), 99);
      check("t4_bcd",     int'(BCD),   8'h19);
      check("t4_bcd1",    int'(BCD1),  8'h19);
      press(4'b1110, 1);
      check("t4_up_wrap", int'(count), 0);
      check("t4_bcd0",    int'(BCD),   8'h03);

      // Code changes while held: ignored in HOLD, honoured in REPEAT,
      // multi-press in REPEAT executes nothing.
      do_reset();
      @(negedge CLK);
      hold_for(4'b1110, 1);  // 0 -> 1
      hold_for(4'b1101, 2);  // HOLD, then enter REPEAT
      hold_for(4'b1101, 1);  // 1 -> 0
      hold_for(4'b1100, 1);  // multi: no action
      hold_for(4'b1101, 1);  // 0 -> 99
      btn = 4'hF;
      cycles(3 * TICK_DIV);
      check("chg_count", int'(count), 99);
      check("chg_steps", n_steps,     3);

      // 5: reach 42 by auto-repeat, then multi and clear
      do_reset();
      press(4'b1110, 44);
      check("t5_count42", int'(count), 42);
      check("t5_bcd",     int'(BCD),   8'h25);
      check("t5_bcd1",    int'(BCD1),  8'h99);
      s0 = n_steps;
      press(4'b1100, 2);
      check("t5_multi",       int'(count), 42);
      check("t5_multi_steps", n_steps - s0, 0);
      press(4'b1011, 1);
      check("t5_clr",       int'(count), 0);
      check("t5_clr_steps", n_steps - s0, 1);
      press(4'b1011, 1);
      check("t5_clr_at0_steps", n_steps - s0, 2);

      // 6: reset during REPEAT with the key held
      do_reset();
      @(negedge CLK);
      btn = 4'b1110;
      cycles(19);
      check("t6_pre_count", int'(count),     3);
      check("t6_pre_rep",   int'(repeating), 1);
      #2 RST_N = 1'b0;
      #1;
      check("t6_rst_count", int'(count),     0);
      check("t6_rst_rep",   int'(repeating), 0);
      check("t6_rst_bcd",   int'(BCD),       8'h03);
      cycles(2);
      RST_N = 1'b1;
      cycles(4);
      check("t6_repress_count", int'(count), 1);
      check("t6_repress_step",  int'(step),  1);
      btn = 4'hF;
      cycles(3 * TICK_DIV);

      cmp_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
      $fatal(1, "watchdog");
   end

endmodule
